snitch_clint_ctrl: RTL

- Synthesizable CLINT-style interrupt controller that drives the per-core software (msip) and timer (mtip) interrupt lines into the Snitch cluster.
- Replaces the DPI-driven msip tick in the test harness with a register-programmed block.
- Sits on a narrow 32-bit register request/response port, hooked behind the narrow out port via a simple AXI-to-reg bridge.
- Holds a 64-bit mtime counter, per-core mtimecmp registers and per-core msip bits.

---
 rtl/snitch_clint_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/snitch_clint_ctrl.sv
// CLINT-style msip/mtip controller behind a 32-bit register request/response port.
// Optional SNITCH_CLINT_PRESCALER_EN: mtime is driven by an internal clock prescaler instead of tick_i.
module snitch_clint_ctrl #(
  parameter int unsigned NrCores       = 9,
  parameter int unsigned AddrWidth     = 16,
  parameter logic [63:0] MtimeResetVal = 64'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);

  // Handshake: a request transfers when req_valid_i && req_ready_o; the response
  // transfers when rsp_valid_o && rsp_ready_i and rsp_* hold steady until then.
  typedef enum logic {StIdle, StResp} state_e;

  localparam logic [AddrWidth-1:0] MsipEnd  = AddrWidth'(4 * NrCores);
  localparam logic [AddrWidth-1:0] CmpBase  = AddrWidth'(32'h4000);
  localparam logic [AddrWidth-1:0] CmpEnd   = AddrWidth'(32'h4000 + 8 * NrCores);
  localparam logic [AddrWidth-1:0] MtimeLo  = AddrWidth'(32'hBFF8);
  localparam logic [AddrWidth-1:0] MtimeHi  = AddrWidth'(32'hBFFC);

  state_e               state_q;
  logic [31:0]          rsp_rdata_q;
  logic                 rsp_error_q;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NrCores];
  logic [63:0]          mtimecmp_d [NrCores];
  logic [NrCores-1:0]   msip_q, msip_d, mtip_q, mtip_d;
  logic [31:0]          rdata_d;
  logic                 error_d, mtime_wr, mtime_tick, accept;
  logic [AddrWidth-1:0] addr_w, cmp_off;
  logic [4:0]           msip_idx, cmp_idx;
  logic                 unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    for (int b = 0; b < 4; b++) merge[8*b +: 8] = st[b] ? wd[8*b +: 8] : old[8*b +: 8];
  endfunction

  assign addr_w      = {req_addr_i[AddrWidth-1:2], 2'b00};
  assign unused_addr = ^req_addr_i[1:0];
  assign cmp_off     = addr_w - CmpBase;
  assign msip_idx    = addr_w[6:2];
  assign cmp_idx     = cmp_off[7:3];
  assign accept      = req_valid_i && (state_q == StIdle);

`ifdef SNITCH_CLINT_PRESCALER_EN
  localparam logic [AddrWidth-1:0] PresAddr = AddrWidth'(32'hC000);
  logic [15:0] presc_q, presc_d, divisor_q, divisor_d;
  logic        presc_wr, unused_tick;
  assign unused_tick = tick_i;
  assign mtime_tick  = (presc_q == divisor_q - 16'd1);
`else
  assign mtime_tick  = tick_i;
`endif

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = '0;
    error_d    = 1'b0;
    mtime_wr   = 1'b0;
`ifdef SNITCH_CLINT_PRESCALER_EN
    divisor_d  = divisor_q;
    presc_wr   = 1'b0;
`endif
    if (accept) begin
      if (addr_w < MsipEnd) begin
        for (int i = 0; i < int'(NrCores); i++) begin
          if (int'(msip_idx) == i) begin
            rdata_d = {31'b0, msip_q[i]};
            if (req_write_i && req_wstrb_i[0]) msip_d[i] = req_wdata_i[0];
          end
        end
      end else if (addr_w >= CmpBase && addr_w < CmpEnd) begin
        for (int i = 0; i < int'(NrCores); i++) begin
          if (int'(cmp_idx) == i) begin
            if (addr_w[2]) begin
              rdata_d = mtimecmp_q[i][63:32];
              if (req_write_i)
                mtimecmp_d[i][63:32] = merge(mtimecmp_q[i][63:32], req_wdata_i, req_wstrb_i);
            end else begin
              rdata_d = mtimecmp_q[i][31:0];
              if (req_write_i)
                mtimecmp_d[i][31:0] = merge(mtimecmp_q[i][31:0], req_wdata_i, req_wstrb_i);
            end
          end
        end
      end else if (addr_w == MtimeLo) begin
        rdata_d  = mtime_q[31:0];
        mtime_wr = req_write_i;
        if (req_write_i) mtime_d[31:0] = merge(mtime_q[31:0], req_wdata_i, req_wstrb_i);
      end else if (addr_w == MtimeHi) begin
        rdata_d  = mtime_q[63:32];
        mtime_wr = req_write_i;
        if (req_write_i) mtime_d[63:32] = merge(mtime_q[63:32], req_wdata_i, req_wstrb_i);
`ifdef SNITCH_CLINT_PRESCALER_EN
      end else if (addr_w == PresAddr) begin
        rdata_d = {16'b0, divisor_q};
        if (req_write_i) begin
          divisor_d = merge({16'b0, divisor_q}, req_wdata_i, req_wstrb_i) & 32'hFFFF;
          if (divisor_d == 16'd0) divisor_d = 16'd1;
          presc_wr  = 1'b1;
        end
`endif
      end else begin
        error_d = 1'b1;
      end
      if (req_write_i || error_d) rdata_d = '0;
    end
    // A register write to mtime wins over the increment in the same cycle.
    if (mtime_tick && !mtime_wr) mtime_d = mtime_q + 64'd1;
  end

  always_comb begin
    for (int i = 0; i < int'(NrCores); i++) mtip_d[i] = (mtime_d >= mtimecmp_d[i]);
`ifdef SNITCH_CLINT_PRESCALER_EN
    presc_d = (presc_wr || mtime_tick) ? 16'd0 : presc_q + 16'd1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= MtimeResetVal;
      for (int i = 0; i < int'(NrCores); i++) mtimecmp_q[i] <= '1;
      msip_q  <= '0;
      mtip_q  <= '0;
`ifdef SNITCH_CLINT_PRESCALER_EN
      presc_q   <= 16'd0;
      divisor_q <= 16'd1;
`endif
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
`ifdef SNITCH_CLINT_PRESCALER_EN
      presc_q   <= presc_d;
      divisor_q <= divisor_d;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (req_valid_i) begin
          state_q     <= StResp;
          rsp_rdata_q <= rdata_d;
          rsp_error_q <= error_d;
        end
        StResp: if (rsp_ready_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign msip_o      = msip_q;
  assign mtip_o      = mtip_q;

endmodule
